// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEFAULT_AWIDTH = 32;
  localparam int unsigned DEFAULT_DWIDTH = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_I    = 2'd1,
    SRC_D    = 2'd2
  } arb_src_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch and data ports; prio_d picks the
// contention winner, single requesters always win.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  logic     prio_d,
  output arb_src_e win
);

  always_comb begin
    win = SRC_NONE;
    if (i_req && d_req) begin
      win = prio_d ? SRC_D : SRC_I;
    end else if (i_req) begin
      win = SRC_I;
    end else if (d_req) begin
      win = SRC_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter with same-cycle grants.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating contention; default is data-port priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH = DEFAULT_AWIDTH,
  parameter int unsigned DWIDTH = DEFAULT_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [AWIDTH-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DWIDTH-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  arb_src_e win_c;
  arb_src_e gnt_src;
  arb_src_e tag_q;
  logic     prio_d;

  mem_arb_pick u_pick (
    .i_req  (i_req_i),
    .d_req  (d_req_i),
    .prio_d (prio_d),
    .win    (win_c)
  );

  // Reset must silence grants immediately, not just at the next edge.
  assign gnt_src = rst ? SRC_NONE : win_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic prio_d_q;

  // Flips to the loser of every contended grant; fetch wins first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_d_q <= 1'b0;
    end else if (i_req_i && d_req_i) begin
      prio_d_q <= (gnt_src == SRC_I);
    end
  end

  assign prio_d = prio_d_q;
`else
  assign prio_d = 1'b1;
`endif

  always_comb begin
    i_gnt_o        = 1'b0;
    d_gnt_o        = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    unique case (gnt_src)
      SRC_I: begin
        i_gnt_o       = 1'b1;
        mem_addr_o    = i_addr_i;
        mem_read_en_o = 1'b1;
      end
      SRC_D: begin
        d_gnt_o    = 1'b1;
        mem_addr_o = d_addr_i;
        if (d_we_i) begin
          mem_write_en_o = 1'b1;
          mem_data_o     = d_wdata_i;
        end else begin
          mem_read_en_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Response tag: which port owns the read data arriving next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= SRC_NONE;
    end else if (gnt_src == SRC_D && d_we_i) begin
      tag_q <= SRC_NONE;
    end else begin
      tag_q <= gnt_src;
    end
  end

  assign i_rvalid_o = (tag_q == SRC_I);
  assign d_rvalid_o = (tag_q == SRC_D);
  assign i_rdata_o  = i_rvalid_o ? mem_data_i : '0;
  assign d_rdata_o  = d_rvalid_o ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed stimulus, a transaction-level
// model checked every cycle, and literal expectations for the key scenarios.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_data;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_data_i = 32'h0BADF00D;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_i        (i_req),
    .i_addr_i       (i_addr),
    .i_gnt_o        (i_gnt),
    .i_rvalid_o     (i_rvalid),
    .i_rdata_o      (i_rdata),
    .d_req_i        (d_req),
    .d_we_i         (d_we),
    .d_addr_i       (d_addr),
    .d_wdata_i      (d_wdata),
    .d_gnt_o        (d_gnt),
    .d_rvalid_o     (d_rvalid),
    .d_rdata_o      (d_rdata),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_data),
    .mem_read_en_o  (mem_read_en),
    .mem_write_en_o (mem_write_en),
    .mem_data_i     (mem_data_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Bench memory: unwritten locations read back as ~addr, data one cycle after read enable.
  logic [31:0] bmem [logic [31:0]];
  logic        rd_pend = 1'b0;
  logic [31:0] rd_addr = '0;

  always @(negedge clk) begin
    rd_pend = mem_read_en;
    rd_addr = mem_addr;
    if (mem_write_en) bmem[mem_addr] = mem_data;
  end

  always @(posedge clk) begin
    if (rd_pend) mem_data_i <= bmem.exists(rd_addr) ? bmem[rd_addr] : ~rd_addr;
    else         mem_data_i <= 32'h0BADF00D;
  end

  // Transaction-level model: pending response owner, its data, and last contended winner.
  logic [31:0] m_mem [logic [31:0]];
  int          m_pend = 0;
  logic [31:0] m_pend_data = '0;
  bit          m_last_i = 1'b0;
  int          s_win = 0;
  bit          s_cont = 1'b0;
  bit          s_we = 1'b0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_wdata = '0;

  always @(negedge clk) begin
    int          win;
    bit          er, ew;
    logic [31:0] ea, ed;
    win = 0; er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
    if (!rst) begin
      if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = m_last_i ? 2 : 1;
`else
        win = 2;
`endif
      end else if (i_req) win = 1;
      else if (d_req) win = 2;
      if (win == 1) begin
        er = 1'b1; ea = i_addr;
      end else if (win == 2) begin
        ea = d_addr;
        if (d_we) begin ew = 1'b1; ed = d_wdata; end
        else er = 1'b1;
      end
    end
    chk("i_gnt", 32'(i_gnt), 32'(win == 1));
    chk("d_gnt", 32'(d_gnt), 32'(win == 2));
    chk("mem_read_en", 32'(mem_read_en), 32'(er));
    chk("mem_write_en", 32'(mem_write_en), 32'(ew));
    chk("mem_addr", mem_addr, ea);
    chk("mem_data", mem_data, ed);
    chk("i_rvalid", 32'(i_rvalid), 32'(!rst && m_pend == 1));
    chk("d_rvalid", 32'(d_rvalid), 32'(!rst && m_pend == 2));
    chk("i_rdata", i_rdata, (!rst && m_pend == 1) ? m_pend_data : 32'h0);
    chk("d_rdata", d_rdata, (!rst && m_pend == 2) ? m_pend_data : 32'h0);
    s_win = win; s_cont = !rst && i_req && d_req; s_we = ew; s_addr = ea; s_wdata = ed;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0;
      m_last_i = 1'b0;
    end else begin
      m_pend = 0;
      if (s_win != 0) begin
        if (s_we) m_mem[s_addr] = s_wdata;
        else begin
          m_pend = s_win;
          m_pend_data = m_mem.exists(s_addr) ? m_mem[s_addr] : ~s_addr;
        end
      end
      if (s_cont) m_last_i = (s_win == 1);
    end
  end

  task automatic apply(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] i_pat, d_pat, exp_i_pat, exp_d_pat;
    logic [1:0] i_pat2, d_pat2, exp_i_pat2, exp_d_pat2;

    // Requests held during reset must not be granted.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h55;
    @(negedge clk);
    chk("rst_i_gnt", 32'(i_gnt), 32'h0);
    chk("rst_d_gnt", 32'(d_gnt), 32'h0);
    chk("rst_write_en", 32'(mem_write_en), 32'h0);
    chk("rst_mem_data", mem_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);

    // Fetch-only read
    apply(1'b1, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fetch_gnt", 32'(i_gnt), 32'h1);
    chk("fetch_read_en", 32'(mem_read_en), 32'h1);
    chk("fetch_addr", mem_addr, 32'h0100_0000);
    idle();
    chk("fetch_rvalid", 32'(i_rvalid), 32'h1);
    chk("fetch_rdata", i_rdata, 32'hFEFF_FFFF);
    chk("fetch_no_d_rvalid", 32'(d_rvalid), 32'h0);

    // Data write, then no response, then read it back
    apply(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("wr_gnt", 32'(d_gnt), 32'h1);
    chk("wr_write_en", 32'(mem_write_en), 32'h1);
    chk("wr_read_en", 32'(mem_read_en), 32'h0);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_data", mem_data, 32'hDEAD_BEEF);
    idle();
    chk("wr_no_rvalid1", 32'(d_rvalid | i_rvalid), 32'h0);
    idle();
    chk("wr_no_rvalid2", 32'(d_rvalid | i_rvalid), 32'h0);
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("drd_gnt", 32'(d_gnt), 32'h1);
    idle();
    chk("drd_rvalid", 32'(d_rvalid), 32'h1);
    chk("drd_rdata", d_rdata, 32'hDEAD_BEEF);

    // Four contended cycles, both reading
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
      i_pat[k] = i_gnt;
      d_pat[k] = d_gnt;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_i_pat = 4'b0101; exp_d_pat = 4'b1010;
`else
    exp_i_pat = 4'b0000; exp_d_pat = 4'b1111;
`endif
    chk("cont_i_pattern", 32'(i_pat), 32'(exp_i_pat));
    chk("cont_d_pattern", 32'(d_pat), 32'(exp_d_pat));
    idle();

    // Back-to-back fetch reads
    apply(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_gnt0", 32'(i_gnt), 32'h1);
    apply(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_gnt1", 32'(i_gnt), 32'h1);
    chk("b2b_rdata0", i_rdata, 32'hFFFF_FFFF);
    apply(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_gnt2", 32'(i_gnt), 32'h1);
    chk("b2b_rdata1", i_rdata, 32'hFFFF_FFFB);
    idle();
    chk("b2b_rvalid2", 32'(i_rvalid), 32'h1);
    chk("b2b_rdata2", i_rdata, 32'hFFFF_FFF7);

    // Reset while a read response is pending
    apply(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rstmid_gnt", 32'(i_gnt), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_i_gnt", 32'(i_gnt), 32'h0);
    chk("rstmid_read_en", 32'(mem_read_en), 32'h0);
    chk("rstmid_addr", mem_addr, 32'h0);
    chk("rstmid_i_rvalid", 32'(i_rvalid), 32'h0);
    @(posedge clk);
    #1;
    chk("rstmid_after_edge_rvalid", 32'(i_rvalid | d_rvalid), 32'h0);
    chk("rstmid_after_edge_rdata", i_rdata, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; i_req = 1'b0;
    @(negedge clk);
    chk("postrst_i_rvalid", 32'(i_rvalid), 32'h0);
    chk("postrst_d_rvalid", 32'(d_rvalid), 32'h0);
    idle();

    // First contention after reset
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 32'h300, 1'b1, 1'b0, 32'h304, 32'h0);
      i_pat2[k] = i_gnt;
      d_pat2[k] = d_gnt;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_i_pat2 = 2'b01; exp_d_pat2 = 2'b10;
`else
    exp_i_pat2 = 2'b00; exp_d_pat2 = 2'b11;
`endif
    chk("postrst_cont_i", 32'(i_pat2), 32'(exp_i_pat2));
    chk("postrst_cont_d", 32'(d_pat2), 32'(exp_d_pat2));

    // Contention with a data write, then mixed single requests
    apply(1'b1, 32'h30, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
    apply(1'b1, 32'h30, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
    apply(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    chk("mixed_fetch_rdata", i_rdata, 32'h1234_5678);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
